// File: rtl/button_event_decoder.sv
// Button gesture decoder: turns the conditioned button level into press/release
// pulses and single/double/long events held in a valid/ack event register.
//
// Ports:
//   clk, rst_n     clock and synchronous active-low reset
//   btn_level      conditioned button level, 1 = pressed
//   press_pulse    one-cycle pulse after each rising edge of btn_level
//   release_pulse  one-cycle pulse after each falling edge of btn_level
//   event_valid    event register holds an unacknowledged event
//   event_code     01 single, 10 double, 11 long; 00 when no event is held
//   event_ack      consumer clears the event register
//   event_overrun  sticky: an event was overwritten before being acked
module button_event_decoder #(
    parameter int LONG_PRESS_CYCLES = 25000000,
    parameter int DCLICK_GAP_CYCLES = 12500000,
    parameter int CTR_W             = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       event_valid,
    output logic [1:0] event_code,
    input  logic       event_ack,
    output logic       event_overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS1,
        S_LONG_HELD,
        S_GAP,
        S_PRESS2
    } state_t;

    localparam logic [CTR_W-1:0] LONG_LAST = CTR_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CTR_W-1:0] GAP_LAST  = CTR_W'(DCLICK_GAP_CYCLES - 1);

    localparam logic [1:0] CODE_SINGLE = 2'b01;
    localparam logic [1:0] CODE_DOUBLE = 2'b10;
    localparam logic [1:0] CODE_LONG   = 2'b11;

    state_t           state_q;
    state_t           state_d;
    logic [CTR_W-1:0] timer_q;
    logic             btn_q;
    logic             rise;
    logic             fall;
    logic             emit;
    logic [1:0]       code_new;

    assign rise = btn_level & ~btn_q;
    assign fall = ~btn_level & btn_q;

    always_comb begin
        state_d  = state_q;
        emit     = 1'b0;
        code_new = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (rise) state_d = S_PRESS1;
            end
            S_PRESS1: begin
                if (fall) begin
                    state_d = S_GAP;
                end else if (timer_q == LONG_LAST) begin
                    state_d  = S_LONG_HELD;
                    emit     = 1'b1;
                    code_new = CODE_LONG;
                end
            end
            S_LONG_HELD: begin
                if (fall) state_d = S_IDLE;
            end
            S_GAP: begin
                // A second press wins over the timeout in the same cycle.
                if (rise) begin
                    state_d = S_PRESS2;
                end else if (timer_q == GAP_LAST) begin
                    state_d  = S_IDLE;
                    emit     = 1'b1;
                    code_new = CODE_SINGLE;
                end
            end
            S_PRESS2: begin
                if (fall) begin
                    state_d  = S_IDLE;
                    emit     = 1'b1;
                    code_new = CODE_DOUBLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            btn_q         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            event_valid   <= 1'b0;
            event_code    <= 2'b00;
            event_overrun <= 1'b0;
        end else begin
            btn_q         <= btn_level;
            press_pulse   <= rise;
            release_pulse <= fall;
            state_q       <= state_d;

            // Timer measures time spent in the current state; it
            // saturates so long idle periods never alias a timeout.
            if (state_d != state_q) begin
                timer_q <= '0;
            end else if (timer_q != '1) begin
                timer_q <= timer_q + 1'b1;
            end

            if (emit) begin
                event_valid   <= 1'b1;
                event_code    <= code_new;
                // Overwriting an unacked event is an overrun; an ack in
                // the same cycle means the old event was consumed.
                event_overrun <= event_valid & ~event_ack;
            end else if (event_ack && event_valid) begin
                event_valid   <= 1'b0;
                event_code    <= 2'b00;
                event_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Randomized scoreboard bench for button_event_decoder.
// Expected outputs come from a timestamp-based gesture model.
module tb_button_event_decoder;

    localparam int LONG = 8;
    localparam int GAP  = 4;

    typedef struct packed {
        logic       pp;
        logic       rp;
        logic       v;
        logic [1:0] c;
        logic       ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_level = 1'b0;
    logic       event_ack = 1'b0;
    logic       press_pulse;
    logic       release_pulse;
    logic       event_valid;
    logic [1:0] event_code;
    logic       event_overrun;

    int checks = 0;
    int failures = 0;

    exp_t exp_q[$];

    // Reference model state.
    int   n = 0;
    logic m_p = 1'b0;
    logic m_busy = 1'b0;
    int   m_presses = 0;
    logic m_long = 1'b0;
    int   m_t = 0;
    logic m_v = 1'b0;
    logic [1:0] m_c = 2'b00;
    logic m_ov = 1'b0;

    button_event_decoder #(
        .LONG_PRESS_CYCLES(LONG),
        .DCLICK_GAP_CYCLES(GAP),
        .CTR_W(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_level(btn_level),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .event_valid(event_valid),
        .event_code(event_code),
        .event_ack(event_ack),
        .event_overrun(event_overrun)
    );

    always #5 clk = ~clk;

    // Predicts the outputs visible after the coming clock edge.
    task automatic model_step(input logic b, input logic a, input logic r);
        exp_t e;
        logic rise, fall, emit;
        logic [1:0] code;
        n++;
        e = '0;
        if (!r) begin
            m_p = 1'b0; m_busy = 1'b0; m_presses = 0; m_long = 1'b0;
            m_v = 1'b0; m_c = 2'b00; m_ov = 1'b0;
        end else begin
            rise = b & ~m_p;
            fall = ~b & m_p;
            emit = 1'b0;
            code = 2'b00;
            if (!m_busy) begin
                if (rise) begin
                    m_busy = 1'b1; m_presses = 1; m_long = 1'b0; m_t = n;
                end
            end else if (m_presses == 1 && m_p) begin
                if (fall) begin
                    if (m_long) m_busy = 1'b0;
                    else m_t = n;
                end else if (!m_long && n - m_t == LONG) begin
                    emit = 1'b1; code = 2'b11; m_long = 1'b1;
                end
            end else if (m_presses == 1) begin
                if (rise) begin
                    m_presses = 2; m_t = n;
                end else if (n - m_t == GAP) begin
                    emit = 1'b1; code = 2'b01; m_busy = 1'b0;
                end
            end else begin
                if (fall) begin
                    emit = 1'b1; code = 2'b10; m_busy = 1'b0;
                end
            end
            if (emit) begin
                m_ov = m_v & ~a;
                m_v  = 1'b1;
                m_c  = code;
            end else if (a && m_v) begin
                m_v = 1'b0; m_c = 2'b00; m_ov = 1'b0;
            end
            e.pp = rise;
            e.rp = fall;
            m_p = b;
        end
        e.v  = m_v;
        e.c  = m_c;
        e.ov = m_ov;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic b, input logic a, input logic r);
        @(negedge clk);
        #1;
        btn_level = b;
        event_ack = a;
        rst_n     = r;
        model_step(b, a, r);
    endtask

    task automatic run(input logic b, input int len);
        for (int i = 0; i < len; i++) cyc(b, 1'b0, 1'b1);
    endtask

    task automatic chk(input string nm, input logic [1:0] act,
                       input logic [1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%b required=%b",
                     nm, checks / 5, act, req);
        end
    endtask

    // Monitor: compares every presented output against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("press_pulse", {1'b0, press_pulse}, {1'b0, e.pp});
                chk("release_pulse", {1'b0, release_pulse}, {1'b0, e.rp});
                chk("event_valid", {1'b0, event_valid}, {1'b0, e.v});
                chk("event_code", event_code, e.c);
                chk("event_overrun", {1'b0, event_overrun}, {1'b0, e.ov});
            end
        end
    end

    initial begin
        int len;
        logic lvl;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
        run(1'b0, 2);

        // Single click, then ack.
        run(1'b1, 3); run(1'b0, 10);
        cyc(1'b0, 1'b1, 1'b1); run(1'b0, 3);

        // Double click.
        run(1'b1, 2); run(1'b0, 2); run(1'b1, 2); run(1'b0, 8);
        cyc(1'b0, 1'b1, 1'b1); run(1'b0, 2);

        // Long press, held well past timer saturation.
        run(1'b1, 40); run(1'b0, 6);
        cyc(1'b0, 1'b1, 1'b1); run(1'b0, 2);

        // Overrun, then ack in the landing cycle of the next event.
        run(1'b1, 2); run(1'b0, 6);
        run(1'b1, 2); run(1'b0, 6);
        run(1'b1, 2); run(1'b0, 4);
        cyc(1'b0, 1'b1, 1'b1); run(1'b0, 3);
        cyc(1'b0, 1'b1, 1'b1); run(1'b0, 2);

        // Reset during GAP, then button held across reset release.
        run(1'b1, 2); run(1'b0, 2);
        cyc(1'b0, 1'b0, 1'b0); run(1'b0, 8);
        cyc(1'b1, 1'b0, 1'b0); cyc(1'b1, 1'b0, 1'b0);
        run(1'b1, 3); run(1'b0, 8);
        cyc(1'b0, 1'b1, 1'b1); run(1'b0, 2);

        // Second press exactly on the GAP timeout, and one cycle late.
        run(1'b1, 2); run(1'b0, GAP); run(1'b1, 2); run(1'b0, 6);
        cyc(1'b0, 1'b1, 1'b1);
        run(1'b1, 2); run(1'b0, GAP + 1); run(1'b1, 2); run(1'b0, 8);
        cyc(1'b0, 1'b1, 1'b1); run(1'b0, 2);

        // Random gestures with random acks and occasional resets.
        lvl = 1'b0;
        for (int s = 0; s < 400; s++) begin
            lvl = ~lvl;
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++)
                cyc(lvl, ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 199) != 0));
        end
        run(1'b0, 12);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
